rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
Parametrised N-channel, W-bit multiplexer that selects its source by arbitration instead of by a static select input. It arbitrates among N_CH valid/ready input channels and registers the winner's data into a single output stage with a valid/ready handshake. It is the next generation of the gate-level 2:1/4:1 muxes and is used wherever several producers share one consumer.

Parameters:
N_CH, 4, number of input channels (>= 2; non-power-of-2 values allowed).
W, 4, data width per channel.
MODE, 1, arbitration policy: 0 = fixed priority (channel 0 highest); 1 = round-robin.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous reset, active low.
in_valid  input  N_CH  per-channel request.
in_ready  output  N_CH  per-channel accept; one-hot or zero.
in_data  input  N_CH*W  packed channel data; channel i occupies bits [i*W +: W].
out_valid  output  1  output register holds a word.
out_ready  input  1  consumer accepts the word.
out_data  output  W  registered selected data.
out_ch  output  CH_W  index of the channel that supplied out_data; CH_W = max(1, clog2(N_CH)).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values (rst_n = 0, applied immediately without waiting for a clock edge): out_valid = 0, out_data = 0, out_ch = 0, RR pointer = 0. While rst_n = 0, in_ready = 0.
- Stage free: slot_free = ~out_valid | out_ready.
- Grant: combinational one-hot grant[N_CH] computed from in_valid and the pointer.
  - MODE 0: lowest-index valid channel wins.
  - MODE 1: the first valid channel at or after the pointer wins, searching upward and wrapping from N_CH-1 to 0.
  - grant = 0 when no channel is valid.
- in_ready = grant & {N_CH{slot_free}}. A channel's ready never depends on another channel's data.
- Transfer on channel i: in_valid[i] & in_ready[i]. On that edge:
  - out_data <= in_data of channel i;
  - out_ch <= i;
  - out_valid <= 1;
  - pointer <= i+1, wrapping to 0 when i = N_CH-1. MODE 0 leaves the pointer unused and held at 0.
- No transfer and out_ready = 1: out_valid <= 0. out_data and out_ch hold their last values.
- No transfer and out_ready = 0: all output state holds.
- Simultaneous drain and fill (out_valid = 1, out_ready = 1, new transfer in the same cycle): the new word replaces the old one and out_valid stays 1. Full throughput is one word per clock.
- Latency: exactly one clock from the accepting edge to out_valid = 1.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_ch are stable and in_ready = 0.
- Data select: AND-OR form only, i.e. OR over i of (in_data[i] & {W{grant[i]}}). No case or ternary index.
  - Consequence: X or Z on a non-granted channel must not reach out_data.
- Pointer handling: the pointer is never advanced by a non-transfer cycle. Requests that drop while waiting are not remembered.
- Mid-operation reset: any word held in the output stage is discarded. Arbitration restarts from channel 0.

Decomposition:
- Package rr_arb_mux_pkg: MODE_FIXED = 0, MODE_RR = 1; a function computing CH_W from N_CH.
- Sub-module rr_arbiter: combinational, parameters N_CH and MODE; inputs req and ptr; output one-hot grant.
  - Implemented as a double-width request vector rotated by ptr, then a priority pick. The same block is reusable elsewhere.
- rr_arb_mux holds the pointer, the output register and the AND-OR data select.

Test Plan:
(N_CH = 4, W = 4, MODE = 1 unless stated.)
1. Reset: hold rst_n = 0 with all in_valid = 1 -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0000. Release rst_n -> first grant goes to channel 0.
2. Single request: in_valid = 0100, ch2 data = 0xC, out_ready = 1 -> in_ready = 0100 that cycle; next cycle out_valid = 1, out_data = 0xC, out_ch = 2; then out_valid = 0 once in_valid drops.
3. Round-robin with wrap: all valid, data 0xA/0xB/0xC/0xD, out_ready = 1 constantly -> over 5 cycles out_data = A, B, C, D, A and out_ch = 0, 1, 2, 3, 0, with no bubbles.
4. Backpressure: after out_data = 0xB, drop out_ready for 3 cycles -> out_data = 0xB and out_ch = 1 stable, in_ready = 0000. Raise out_ready -> next word is 0xC from channel 2.
5. X isolation: ch0 = 7, ch1 = 10, ch2 = 3, ch3 = X; in_valid = 0001 -> out_data === 7. Then in_valid = 1000 -> out_data === X; this is the only case where X is allowed to appear.
6. MODE 0 and mid-stream reset:
   - MODE 0, all valid, out_ready = 1 -> channel 0 is granted every cycle.
   - MODE 1, pulse rst_n low while out_valid = 1 and pointer = 2 -> out_valid is 0 immediately, and the next grant after release goes to channel 0.

Source files
------------

// File: rtl/rr_arb_mux_pkg.sv
// Shared constants for the arbitrated mux: arbitration modes and channel-index width.
// Pure declarations, no timing or handshake behaviour.
// Imported by the arbiter, the interface and the mux top.
package rr_arb_mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int calc_ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N_CH producers, the arbitrated mux and one consumer.
// Signals only, no latency of its own.
// The slave view is the mux; the master view is the producers/consumer side.
interface rr_arb_mux_if #(
    parameter int N_CH = 4,
    parameter int W    = 4
);
    import rr_arb_mux_pkg::*;

    localparam int CH_W = calc_ch_w(N_CH);

    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [N_CH*W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// One-hot grant among N_CH requests, fixed priority or round-robin from ptr.
// Purely combinational, zero latency.
// No backpressure of its own; callers qualify the grant with their own ready.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int MODE = MODE_RR,
    localparam int CH_W = calc_ch_w(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] grant
);

    logic [CH_W-1:0]   base;
    logic [2*N_CH-1:0] dbl_req;
    logic [2*N_CH-1:0] dbl_pick;
    logic [N_CH-1:0]   rot;
    logic [N_CH-1:0]   pick;

    assign base = (MODE == MODE_RR) ? ptr : '0;

    // Rotate so the pointer channel sits at bit 0, take the lowest set bit,
    // then rotate the pick back into channel positions.
    assign dbl_req  = {req, req} >> base;
    assign rot      = N_CH'(dbl_req);
    assign pick     = rot & (~rot + N_CH'(1));
    assign dbl_pick = {pick, pick} >> (N_CH - int'(base));
    assign grant    = N_CH'(dbl_pick);

endmodule

// File: rtl/rr_arb_mux.sv
// Arbitrated N_CH:1 mux registering the winning channel's word and index.
// Latency: one clock from accepting edge to out_valid; one word per clock sustained.
// Backpressure: out_ready low with a word held keeps output stable and all in_ready low.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 4,
    parameter int MODE = MODE_RR
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_mux_if.slave  bus
);

    localparam int CH_W = calc_ch_w(N_CH);

    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] ptr_nxt;
    logic [CH_W-1:0] gnt_idx;
    logic [W-1:0]    sel_data;
    logic            slot_free;
    logic            xfer;

    rr_arbiter #(
        .N_CH (N_CH),
        .MODE (MODE)
    ) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign slot_free    = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = grant & {N_CH{slot_free & rst_n}};
    // in_ready is a subset of grant, which is a subset of in_valid.
    assign xfer         = |bus.in_ready;

    // AND-OR select keeps unknowns on non-granted channels out of the result.
    always_comb begin
        sel_data = '0;
        gnt_idx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_data = sel_data | (bus.in_data[i*W +: W] & {W{grant[i]}});
            gnt_idx  = gnt_idx | (CH_W'(i) & {CH_W{grant[i]}});
        end
    end

    assign ptr_nxt = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_data;
            bus.out_ch    <= gnt_idx;
            if (MODE == MODE_RR) begin
                ptr <= ptr_nxt;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
